// File: rtl/player_move_ctrl.sv
// Player movement sequencer: synchronises key levels, paces motion with a tick
// divider and runs the IDLE/WALK/CLIMB/JUMP/FALL machine that emits dx/dy steps.
module player_move_ctrl #(
  parameter int STEP_DIV   = 250000,
  parameter int JUMP_TICKS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] move_state,
  input  logic       on_ground,
  input  logic       on_ladder,
  input  logic       freeze,
  output logic       step_valid,
  output logic [1:0] dx,
  output logic [1:0] dy,
  output logic       facing,
  output logic       jumping,
  output logic [1:0] anim_frame,
  output logic [2:0] state_dbg
);

  localparam int CW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam int JW = $clog2(JUMP_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DIV - 1);
  localparam logic [JW-1:0] JCNT_END = JW'(JUMP_TICKS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WALK  = 3'd1,
    CLIMB = 3'd2,
    JUMP  = 3'd3,
    FALL  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    key_s1_q, key_s1_d;
  logic [4:0]    key_s2_q, key_s2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [JW-1:0] jcnt_q, jcnt_d;
  logic [1:0]    hdir_q, hdir_d;
  logic          facing_q, facing_d;
  logic [1:0]    anim_q, anim_d;
  logic          step_valid_q, step_valid_d;
  logic [1:0]    dx_q, dx_d;
  logic [1:0]    dy_q, dy_d;

  logic       tick;
  logic       k_up, k_left, k_right, k_down, k_space;
  logic       h_left, h_right, h_any, v_up, v_down, v_any;
  logic [1:0] h_dir;

  always_comb begin
    key_s1_d = move_state;
    key_s2_d = key_s1_q;

    k_up    = key_s2_q[0];
    k_left  = key_s2_q[1];
    k_right = key_s2_q[2];
    k_down  = key_s2_q[3];
    k_space = key_s2_q[4];

    // Opposing keys cancel each other out rather than picking a winner.
    h_left  = k_left & ~k_right;
    h_right = k_right & ~k_left;
    h_any   = h_left | h_right;
    v_up    = k_up & ~k_down;
    v_down  = k_down & ~k_up;
    v_any   = v_up | v_down;
    h_dir   = h_right ? 2'b01 : (h_left ? 2'b11 : 2'b00);

    tick  = !freeze && (cnt_q == CNT_LAST);
    cnt_d = freeze ? cnt_q : (tick ? '0 : cnt_q + CW'(1));

    state_d      = state_q;
    jcnt_d       = jcnt_q;
    hdir_d       = hdir_q;
    facing_d     = facing_q;
    anim_d       = anim_q;
    step_valid_d = 1'b0;
    dx_d         = 2'b00;
    dy_d         = 2'b00;

    // The frame advances after each walk/climb step has been presented.
    if (step_valid_q && (state_q == WALK || state_q == CLIMB)) begin
      anim_d = anim_q + 2'd1;
    end

    if (tick) begin
      case (state_q)
        IDLE: begin
          if (k_space && on_ground) begin
            state_d = JUMP;
            hdir_d  = h_dir;
            jcnt_d  = '0;
            if (h_any) facing_d = h_right;
          end else if (on_ladder && v_any) begin
            state_d = CLIMB;
          end else if (h_any) begin
            state_d = WALK;
          end else if (!on_ground) begin
            state_d = FALL;
            hdir_d  = 2'b00;
          end
        end
        WALK: begin
          if (!on_ground) begin
            state_d = FALL;
            hdir_d  = 2'b00;
          end else if (k_space) begin
            state_d = JUMP;
            hdir_d  = h_dir;
            jcnt_d  = '0;
            if (h_any) facing_d = h_right;
          end else if (h_any) begin
            step_valid_d = 1'b1;
            dx_d         = h_dir;
            facing_d     = h_right;
          end else begin
            state_d = IDLE;
          end
        end
        CLIMB: begin
          if (!on_ladder) begin
            state_d = IDLE;
          end else if (v_any) begin
            step_valid_d = 1'b1;
            dy_d         = v_up ? 2'b11 : 2'b01;
          end
        end
        JUMP: begin
          step_valid_d = 1'b1;
          dx_d         = hdir_q;
          dy_d         = 2'b11;
          jcnt_d       = jcnt_q + JW'(1);
          if (jcnt_d == JCNT_END) state_d = FALL;
        end
        FALL: begin
          if (on_ground) begin
            state_d = IDLE;
          end else begin
            step_valid_d = 1'b1;
            dx_d         = hdir_q;
            dy_d         = 2'b01;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (state_d == IDLE && state_q != IDLE) anim_d = 2'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      key_s1_q     <= '0;
      key_s2_q     <= '0;
      cnt_q        <= '0;
      jcnt_q       <= '0;
      hdir_q       <= 2'b00;
      facing_q     <= 1'b1;
      anim_q       <= 2'd0;
      step_valid_q <= 1'b0;
      dx_q         <= 2'b00;
      dy_q         <= 2'b00;
    end else begin
      state_q      <= state_d;
      key_s1_q     <= key_s1_d;
      key_s2_q     <= key_s2_d;
      cnt_q        <= cnt_d;
      jcnt_q       <= jcnt_d;
      hdir_q       <= hdir_d;
      facing_q     <= facing_d;
      anim_q       <= anim_d;
      step_valid_q <= step_valid_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
    end
  end

  assign step_valid = step_valid_q;
  assign dx         = dx_q;
  assign dy         = dy_q;
  assign facing     = facing_q;
  assign anim_frame = anim_q;
  assign jumping    = (state_q == JUMP) || (state_q == FALL);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed bench for player_move_ctrl (STEP_DIV=4, JUMP_TICKS=3): expected step
// records are queued as stimulus is applied and popped by a step monitor.
module tb_player_move_ctrl;

  localparam logic [4:0] K_UP    = 5'b00001;
  localparam logic [4:0] K_LEFT  = 5'b00010;
  localparam logic [4:0] K_RIGHT = 5'b00100;
  localparam logic [4:0] K_DOWN  = 5'b01000;
  localparam logic [4:0] K_SPACE = 5'b10000;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_JUMP = 3'd3;
  localparam logic [2:0] S_FALL = 3'd4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] move_state = '0;
  logic       on_ground = 1'b1;
  logic       on_ladder = 1'b0;
  logic       freeze = 1'b0;
  logic       step_valid;
  logic [1:0] dx, dy;
  logic       facing, jumping;
  logic [1:0] anim_frame;
  logic [2:0] state_dbg;

  int total = 0;
  int bad = 0;
  int steps_seen = 0;
  logic [7:0] exp_q[$];

  player_move_ctrl #(.STEP_DIV(4), .JUMP_TICKS(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .move_state (move_state),
    .on_ground  (on_ground),
    .on_ladder  (on_ladder),
    .freeze     (freeze),
    .step_valid (step_valid),
    .dx         (dx),
    .dy         (dy),
    .facing     (facing),
    .jumping    (jumping),
    .anim_frame (anim_frame),
    .state_dbg  (state_dbg)
  );

  // Clock and reset.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step record layout: {dx, dy, facing, jumping, anim_frame}.
  function automatic logic [7:0] mk(input logic [1:0] x, input logic [1:0] y,
                                    input logic f, input logic j, input logic [1:0] a);
    return {x, y, f, j, a};
  endfunction

  // Scoreboard: every step pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (step_valid === 1'b1) begin
        steps_seen++;
        check("step_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          logic [7:0] want;
          want = exp_q.pop_front();
          check("step_record", {24'd0, dx, dy, facing, jumping, anim_frame}, {24'd0, want});
        end
      end else begin
        check("idle_dxdy", {28'd0, dx, dy}, 32'd0);
      end
    end
  end

  // Driver tasks.
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_steps(input int n);
    int target;
    target = steps_seen + n;
    for (int c = 0; c < 40 * n && steps_seen < target; c++) begin
      @(negedge clk);
      #1;
    end
    check("step_timeout", 32'(steps_seen >= target), 32'd1);
  endtask

  initial begin
    // Reset values.
    wait_clks(3);
    check("rst_step_valid", {31'd0, step_valid}, 32'd0);
    check("rst_dxdy", {28'd0, dx, dy}, 32'd0);
    check("rst_facing", {31'd0, facing}, 32'd1);
    check("rst_jumping", {31'd0, jumping}, 32'd0);
    check("rst_anim", {30'd0, anim_frame}, 32'd0);
    check("rst_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
    rst = 1'b0;

    // 1. Reset in the middle of a jump.
    move_state = K_SPACE;
    exp_q.push_back(mk(2'b00, 2'b11, 1'b1, 1'b1, 2'd0));
    wait_steps(1);
    check("t1_in_jump", {29'd0, state_dbg}, {29'd0, S_JUMP});
    rst = 1'b1;
    move_state = '0;
    #1;
    check("t1_rst_step_valid", {31'd0, step_valid}, 32'd0);
    check("t1_rst_dxdy", {28'd0, dx, dy}, 32'd0);
    check("t1_rst_facing", {31'd0, facing}, 32'd1);
    check("t1_rst_jumping", {31'd0, jumping}, 32'd0);
    check("t1_rst_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
    wait_clks(2);
    rst = 1'b0;
    wait_clks(8);

    // 2. Walk right; animation frame cycles through 0..3 and wraps.
    move_state = K_RIGHT;
    for (int i = 0; i < 5; i++) exp_q.push_back(mk(2'b01, 2'b00, 1'b1, 1'b0, 2'(i)));
    wait_steps(5);

    // 3. Both horizontal keys cancel; then walk left.
    move_state = K_LEFT | K_RIGHT;
    wait_clks(12);
    check("t3_cancel_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
    check("t3_cancel_anim", {30'd0, anim_frame}, 32'd0);
    move_state = K_LEFT;
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(2'b11, 2'b00, 1'b0, 1'b0, 2'(i)));
    wait_steps(3);
    check("t3_facing_left", {31'd0, facing}, 32'd0);
    move_state = '0;
    wait_clks(8);
    check("t3_idle_anim", {30'd0, anim_frame}, 32'd0);

    // 4. Jump to the right, fall until the ground returns.
    move_state = K_SPACE | K_RIGHT;
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(2'b01, 2'b11, 1'b1, 1'b1, 2'd0));
    for (int i = 0; i < 2; i++) exp_q.push_back(mk(2'b01, 2'b01, 1'b1, 1'b1, 2'd0));
    wait_steps(1);
    move_state = '0;
    on_ground = 1'b0;
    wait_steps(4);
    check("t4_falling", {29'd0, state_dbg}, {29'd0, S_FALL});
    check("t4_jumping", {31'd0, jumping}, 32'd1);
    on_ground = 1'b1;
    wait_clks(6);
    check("t4_landed_jumping", {31'd0, jumping}, 32'd0);
    check("t4_landed_state", {29'd0, state_dbg}, {29'd0, S_IDLE});

    // 5. Climb up, then down, then leave the ladder.
    on_ladder = 1'b1;
    move_state = K_UP;
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(2'b00, 2'b11, 1'b1, 1'b0, 2'(i)));
    wait_steps(3);
    move_state = K_DOWN;
    exp_q.push_back(mk(2'b00, 2'b01, 1'b1, 1'b0, 2'd3));
    exp_q.push_back(mk(2'b00, 2'b01, 1'b1, 1'b0, 2'd0));
    wait_steps(2);
    on_ladder = 1'b0;
    wait_clks(12);
    check("t5_off_ladder_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
    check("t5_off_ladder_anim", {30'd0, anim_frame}, 32'd0);

    // 6. Freeze while walking; the divider resumes from its held count.
    move_state = K_RIGHT;
    exp_q.push_back(mk(2'b01, 2'b00, 1'b1, 1'b0, 2'd0));
    exp_q.push_back(mk(2'b01, 2'b00, 1'b1, 1'b0, 2'd1));
    wait_steps(2);
    wait_clks(2);
    freeze = 1'b1;
    wait_clks(10);
    exp_q.push_back(mk(2'b01, 2'b00, 1'b1, 1'b0, 2'd2));
    freeze = 1'b0;
    wait_clks(1);
    check("t6_resume_early", {31'd0, step_valid}, 32'd0);
    wait_clks(1);
    check("t6_resume_step", {31'd0, step_valid}, 32'd1);
    move_state = '0;
    wait_clks(8);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
